// File: rtl/uart_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Opcodes, command-byte field positions and FSM states for the
//            UART command sequencer.
// Revision : 1.0
// ============================================================================
package uart_cmd_pkg;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 6;
  localparam int ADDR_MSB   = 5;
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    st_idle      = 3'd0,
    st_collect   = 3'd1,
    st_write     = 3'd2,
    st_read_req  = 3'd3,
    st_read_wait = 3'd4,
    st_send      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Brief    : Turns the tagged RX byte stream into register-bus writes/reads
//            and streams read data back toward the UART TX path.
// Revision : 1.0
// ============================================================================
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    RX_EMPTY_I,
  input  logic [7:0]              RX_DATA_I,
  input  logic                    RX_COMMAND_I,
  output logic                    RX_READ_O,
  output logic [ADDR_WIDTH-1:0]   ADDR_O,
  output logic [WORD_BYTES*8-1:0] WDATA_O,
  output logic                    WE_O,
  output logic                    RE_O,
  input  logic [WORD_BYTES*8-1:0] RDATA_I,
  input  logic                    RVALID_I,
  output logic [7:0]              TX_DATA_O,
  input  logic                    TX_FULL_I,
  output logic                    TX_WRITE_O,
  output logic                    BUSY_O,
  output logic                    ERR_O
);

  localparam int                 c_data_w = WORD_BYTES * 8;
  localparam int                 c_cnt_w  = $clog2(WORD_BYTES) + 1;
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WORD_BYTES - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [c_data_w-1:0]   r_wdata, w_wdata_nxt;
  logic [c_data_w-1:0]   r_rdata, w_rdata_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic                  w_rx_read;
  logic                  w_err;
  logic                  w_tx_write;
  logic [7:0]            w_tx_byte;
  opcode_t               w_opcode;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= st_idle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_rx_read   = 1'b0;
    w_err       = 1'b0;
    w_tx_write  = 1'b0;
    w_opcode    = opcode_t'(RX_DATA_I[OPCODE_MSB:OPCODE_LSB]);
    w_tx_byte   = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (r_cnt == c_cnt_w'(i)) w_tx_byte = r_rdata[i*8 +: 8];
    end

    case (r_state)
      st_idle, st_collect: begin
        if (!RX_EMPTY_I) begin
          w_rx_read = 1'b1;
          if (RX_COMMAND_I) begin
            // A command mid-collect aborts the write and is then decoded as new.
            if (r_state == st_collect) w_err = 1'b1;
            w_state_nxt = st_idle;
            case (w_opcode)
              OP_WRITE: begin
                w_addr_nxt  = RX_DATA_I[ADDR_MSB:ADDR_LSB];
                w_wdata_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = st_collect;
              end
              OP_READ: begin
                w_addr_nxt  = RX_DATA_I[ADDR_MSB:ADDR_LSB];
                w_state_nxt = st_read_req;
              end
              OP_RSVD: w_err = 1'b1;
              default: ;
            endcase
          end else if (r_state == st_collect) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (r_cnt == c_cnt_w'(i)) w_wdata_nxt[i*8 +: 8] = RX_DATA_I;
            end
            if (r_cnt == c_last) w_state_nxt = st_write;
            else                 w_cnt_nxt   = r_cnt + c_cnt_w'(1);
          end else begin
            w_err = 1'b1;
          end
        end
      end
      st_write:    w_state_nxt = st_idle;
      st_read_req: w_state_nxt = st_read_wait;
      st_read_wait: begin
        if (RVALID_I) begin
          w_rdata_nxt = RDATA_I;
          w_cnt_nxt   = '0;
          w_state_nxt = st_send;
        end
      end
      st_send: begin
        if (!TX_FULL_I) begin
          w_tx_write = 1'b1;
          if (r_cnt == c_last) w_state_nxt = st_idle;
          else                 w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        end
      end
      default: w_state_nxt = st_idle;
    endcase

    // Nothing leaves the block while reset is held, even from a stale state.
    if (RST_I) begin
      w_rx_read  = 1'b0;
      w_err      = 1'b0;
      w_tx_write = 1'b0;
    end
  end

  assign RX_READ_O  = w_rx_read;
  assign ERR_O      = w_err;
  assign TX_WRITE_O = w_tx_write;
  assign TX_DATA_O  = w_tx_byte;
  assign ADDR_O     = r_addr;
  assign WDATA_O    = r_wdata;
  assign WE_O       = !RST_I && (r_state == st_write);
  assign RE_O       = !RST_I && (r_state == st_read_req);
  assign BUSY_O     = !RST_I && (r_state != st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Brief    : Randomized self-checking bench; a byte-stream parser model predicts
//            bus writes, reads, TX bytes, error pulses and backpressure.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_sequencer;

  localparam int WORD_BYTES = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        RX_EMPTY_I;
  logic [7:0]  RX_DATA_I;
  logic        RX_COMMAND_I;
  logic        RX_READ_O;
  logic [5:0]  ADDR_O;
  logic [31:0] WDATA_O;
  logic        WE_O;
  logic        RE_O;
  logic [31:0] RDATA_I;
  logic        RVALID_I;
  logic [7:0]  TX_DATA_O;
  logic        TX_FULL_I;
  logic        TX_WRITE_O;
  logic        BUSY_O;
  logic        ERR_O;

  uart_cmd_sequencer #(.WORD_BYTES(WORD_BYTES)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .RX_EMPTY_I(RX_EMPTY_I), .RX_DATA_I(RX_DATA_I), .RX_COMMAND_I(RX_COMMAND_I),
    .RX_READ_O(RX_READ_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .WE_O(WE_O), .RE_O(RE_O), .RDATA_I(RDATA_I), .RVALID_I(RVALID_I),
    .TX_DATA_O(TX_DATA_O), .TX_FULL_I(TX_FULL_I), .TX_WRITE_O(TX_WRITE_O),
    .BUSY_O(BUSY_O), .ERR_O(ERR_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed { logic cmd; logic [7:0] b; } rx_item_t;
  typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;

  rx_item_t    rxq[$];
  wr_t         exp_wr[$];
  logic [5:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];

  int          n_checks = 0;
  int          n_fails  = 0;

  bit          m_collecting = 0;
  bit          m_busy       = 0;
  int          m_cnt        = 0;
  logic [5:0]  m_addr       = '0;
  logic [31:0] m_data       = '0;

  bit          rv_pending  = 0;
  int          rv_wait     = 0;
  logic [31:0] rv_data     = '0;
  bit          first_read  = 1;
  bit          stall_armed = 0;
  int          force_full  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit cmd, input logic [7:0] b);
    rx_item_t it;
    it.cmd = cmd;
    it.b   = b;
    rxq.push_back(it);
  endtask

  // Grammar-level parse of one consumed byte; returns whether it is a protocol error.
  task automatic model_pop(input rx_item_t it, output bit err);
    wr_t w;
    err = 0;
    if (it.cmd) begin
      if (m_collecting) err = 1;
      m_collecting = 0;
      case (it.b[7:6])
        2'b01: begin m_collecting = 1; m_cnt = 0; m_addr = it.b[5:0]; m_data = '0; end
        2'b10: begin exp_rd.push_back(it.b[5:0]); m_busy = 1; end
        2'b11: err = 1;
        default: ;
      endcase
    end else if (m_collecting) begin
      m_data[m_cnt*8 +: 8] = it.b;
      m_cnt++;
      if (m_cnt == WORD_BYTES) begin
        w.addr = m_addr;
        w.data = m_data;
        exp_wr.push_back(w);
        m_collecting = 0;
        m_busy       = 1;
      end
    end else begin
      err = 1;
    end
  endtask

  task automatic step();
    bit   err_exp;
    wr_t  w;
    @(negedge CLK_I);
    RX_EMPTY_I = (rxq.size() == 0) || ($urandom_range(0, 3) == 0);
    if (!RX_EMPTY_I) begin
      RX_DATA_I    = rxq[0].b;
      RX_COMMAND_I = rxq[0].cmd;
    end else begin
      RX_DATA_I    = 8'($urandom);
      RX_COMMAND_I = 1'($urandom);
    end
    TX_FULL_I = (force_full > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    if (force_full > 0) force_full--;
    RVALID_I = 1'b0;
    RDATA_I  = $urandom;
    if (rv_pending) begin
      if (rv_wait == 0) begin
        RVALID_I   = 1'b1;
        RDATA_I    = rv_data;
        rv_pending = 0;
      end else begin
        rv_wait--;
      end
    end
    #1;
    chk("busy", BUSY_O, m_collecting || m_busy);
    chk("rx_read", RX_READ_O, !RX_EMPTY_I && !m_busy);
    err_exp = 0;
    if (RX_READ_O && !RX_EMPTY_I) model_pop(rxq.pop_front(), err_exp);
    chk("err", ERR_O, err_exp);

    if (WE_O) begin
      if (exp_wr.size() == 0) chk("we_unexpected", WE_O, 0);
      else begin
        w = exp_wr.pop_front();
        chk("we_addr", ADDR_O, w.addr);
        chk("we_data", WDATA_O, w.data);
      end
      m_busy = 0;
    end

    if (RE_O) begin
      if (exp_rd.size() == 0) chk("re_unexpected", RE_O, 0);
      else chk("re_addr", ADDR_O, exp_rd.pop_front());
      rv_data     = first_read ? 32'hDEADBEEF : $urandom;
      rv_wait     = first_read ? 1 : $urandom_range(0, 3);
      stall_armed = first_read;
      first_read  = 0;
      rv_pending  = 1;
      for (int b = 0; b < WORD_BYTES; b++) exp_tx.push_back(rv_data[b*8 +: 8]);
    end

    if (TX_WRITE_O) begin
      chk("tx_while_full", TX_FULL_I, 0);
      if (exp_tx.size() == 0) chk("tx_unexpected", TX_WRITE_O, 0);
      else begin
        chk("tx_byte", TX_DATA_O, exp_tx.pop_front());
        if (exp_tx.size() == 0) m_busy = 0;
      end
      if (stall_armed) begin
        force_full  = 3;
        stall_armed = 0;
      end
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((rxq.size() != 0 || m_busy || rv_pending) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("drain_timeout", rxq.size() + int'(m_busy), 0);
    step();
    step();
  endtask

  task automatic gen_random(input int n);
    for (int t = 0; t < n; t++) begin
      int         kind;
      int         k;
      logic [5:0] a;
      kind = $urandom_range(0, 6);
      a    = 6'($urandom);
      case (kind)
        0, 1: begin
          push(1, {2'b01, a});
          for (int j = 0; j < WORD_BYTES; j++) push(0, 8'($urandom));
        end
        2: push(1, {2'b10, a});
        3: push(1, {2'b00, a});
        4: push(1, {2'b11, a});
        5: begin
          push(1, {2'b01, a});
          k = $urandom_range(0, WORD_BYTES - 1);
          for (int j = 0; j < k; j++) push(0, 8'($urandom));
        end
        default: push(0, 8'($urandom));
      endcase
    end
  endtask

  initial begin
    RST_I        = 1'b1;
    RX_EMPTY_I   = 1'b0;
    RX_DATA_I    = 8'h45;
    RX_COMMAND_I = 1'b1;
    TX_FULL_I    = 1'b0;
    RVALID_I     = 1'b0;
    RDATA_I      = '0;
    repeat (3) @(negedge CLK_I);
    #1;
    chk("rst_addr", ADDR_O, 0);
    chk("rst_wdata", WDATA_O, 0);
    chk("rst_we", WE_O, 0);
    chk("rst_re", RE_O, 0);
    chk("rst_rx_read", RX_READ_O, 0);
    chk("rst_tx_write", TX_WRITE_O, 0);
    chk("rst_err", ERR_O, 0);
    chk("rst_busy", BUSY_O, 0);
    RX_EMPTY_I = 1'b1;
    RST_I      = 1'b0;

    push(1, 8'h45); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    push(1, 8'h83);
    push(1, 8'h41); push(0, 8'hAA); push(1, 8'h82);
    push(0, 8'h55); push(1, 8'hC0); push(1, 8'h00);
    drain(2000);

    gen_random(80);
    drain(20000);

    push(1, 8'h47); push(0, 8'h01); push(0, 8'h02);
    drain(200);
    @(negedge CLK_I);
    RST_I      = 1'b1;
    RX_EMPTY_I = 1'b1;
    RVALID_I   = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;
    #1;
    chk("midrst_wdata", WDATA_O, 0);
    chk("midrst_addr", ADDR_O, 0);
    chk("midrst_busy", BUSY_O, 0);
    chk("midrst_we", WE_O, 0);
    m_collecting = 0;

    push(1, 8'h45); push(0, 8'hA1); push(0, 8'hB2); push(0, 8'hC3); push(0, 8'hD4);
    drain(500);

    chk("writes_left", exp_wr.size(), 0);
    chk("reads_left", exp_rd.size(), 0);
    chk("tx_left", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Consumes the escaped RX byte stream, where each byte is tagged data or command, and turns it into register-bus transactions.
- A command byte selects the opcode and address.
- A write command collects WORD_BYTES payload bytes, then issues one write strobe.
- A read command issues a read request, then streams the returned word out byte-wise toward the UART TX path.
- Sits between the RX escape stage and the debug register file.

Parameters:
- WORD_BYTES, default 4: payload bytes per transaction. Legal range 1..8. Data width is WORD_BYTES*8.
- ADDR_WIDTH, fixed at 6: address field taken from command bits [5:0].

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  synchronous, active-high reset
- RX_EMPTY_I  in  1  low = a byte is available upstream
- RX_DATA_I  in  8  byte from the escape stage, valid while RX_EMPTY_I is low
- RX_COMMAND_I  in  1  high = RX_DATA_I is a command byte
- RX_READ_O  out  1  pops the current upstream byte; combinational, same cycle
- ADDR_O  out  6  transaction address
- WDATA_O  out  WORD_BYTES*8  write data, little-endian byte assembly
- WE_O  out  1  one-cycle write strobe
- RE_O  out  1  one-cycle read request
- RDATA_I  in  WORD_BYTES*8  read data
- RVALID_I  in  1  RDATA_I valid; earliest one cycle after RE_O
- TX_DATA_O  out  8  byte toward TX
- TX_FULL_I  in  1  TX cannot accept a byte
- TX_WRITE_O  out  1  pushes TX_DATA_O
- BUSY_O  out  1  high whenever state is not st_idle
- ERR_O  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset:
  - state = st_idle.
  - ADDR_O, WDATA_O, the rdata register and the byte counter are all cleared to 0.
  - WE_O, RE_O, RX_READ_O, TX_WRITE_O, ERR_O and BUSY_O are all 0.
  - Reset mid-transaction abandons it with no strobe issued.
- Command byte format: bits [7:6] are the opcode: 00 NOP, 01 WRITE, 10 READ, 11 reserved. Bits [5:0] are the address.
- st_idle, when RX_EMPTY_I is low: RX_READ_O = 1.
  - Command WRITE: latch ADDR_O, clear WDATA_O, counter = 0, go to st_collect.
  - Command READ: latch ADDR_O, go to st_read_req.
  - Command NOP: stay.
  - Command reserved: pulse ERR_O, stay.
  - Data byte: discard, pulse ERR_O.
- st_collect, when RX_EMPTY_I is low: RX_READ_O = 1.
  - Data byte: written to WDATA_O[cnt*8 +: 8], counter increments. If cnt == WORD_BYTES-1, go to st_write.
  - Command byte: abort the write (no WE_O), pulse ERR_O, and decode the byte exactly as st_idle would in the same cycle.
  - If WORD_BYTES = 1, the first data byte moves straight to st_write.
- st_write: WE_O = 1 for exactly one cycle, then st_idle. WDATA_O and ADDR_O hold until the next command.
- st_read_req: RE_O = 1 for one cycle, then st_read_wait.
- st_read_wait: wait indefinitely. On RVALID_I, latch RDATA_I, counter = 0, go to st_send. RVALID_I outside st_read_wait is ignored.
- st_send:
  - TX_DATA_O = rdata byte[cnt].
  - TX_WRITE_O = !TX_FULL_I.
  - On a push, the counter increments. After byte WORD_BYTES-1 is pushed, go to st_idle.
  - TX_FULL_I stalls with no loss and no duplication.
- Backpressure: RX_READ_O = 0 in st_write, st_read_req, st_read_wait and st_send. Upstream bytes wait.
- Throughput: a write takes 1 + WORD_BYTES byte cycles, then 1 strobe cycle. A back-to-back command is accepted in the cycle after WE_O.
- Counter width: clog2(WORD_BYTES)+1 bits, no wrap beyond WORD_BYTES-1.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode enum (OP_NOP, OP_WRITE, OP_READ, OP_RSVD);
  - the OPCODE_MSB/LSB and ADDR field constants;
  - state_t (st_idle, st_collect, st_write, st_read_req, st_read_wait, st_send).
- Single module with a two-process FSM (registered core plus combinational next-state).
- No sub-module is natural; the byte-lane mux and demux are inline.

Test Plan (WORD_BYTES=4):
- Write: send cmd 0x45, then data 0x11, 0x22, 0x33, 0x44 -> single WE_O pulse with ADDR_O=0x05 and WDATA_O=0x44332211. ERR_O stays 0.
- Read with stall:
  - Stimulus: cmd 0x83; RVALID_I with RDATA_I=0xDEADBEEF 2 cycles after RE_O; TX_FULL_I high for 3 cycles after the first push.
  - Response: one RE_O pulse with ADDR_O=0x03. TX bytes EF, BE, AD, DE in order, exactly 4 pushes. No RX_READ_O until the last push.
- Abort: send cmd 0x41, data 0xAA, then cmd 0x82 -> ERR_O pulse, no WE_O, RE_O with ADDR_O=0x02.
- Stray and reserved bytes: data 0x55 in idle -> popped with an ERR_O pulse. Cmd 0xC0 -> ERR_O pulse. Cmd 0x00 -> no ERR_O. State stays st_idle throughout.
- Reset mid-collect: cmd 0x47, data 0x01, 0x02, then RST_I for 1 cycle -> st_idle, WDATA_O=0, no WE_O. A following full write completes normally.
